// File: rtl/s_z_extend_if.sv
// Bus bundle for the immediate extender: raw immediate in, combinational and
// registered extended values out.
interface s_z_extend_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic             sext;
  logic [IN_W-1:0]  immediate;
  logic [OUT_W-1:0] extendImmediate;
  logic [OUT_W-1:0] ext_q;
  logic             ext_valid;

  modport master (
    output in_valid, sext, immediate,
    input  extendImmediate, ext_q, ext_valid
  );

  modport slave (
    input  in_valid, sext, immediate,
    output extendImmediate, ext_q, ext_valid
  );
endinterface

// File: rtl/s_z_extend.sv
// Sign/zero extender for I-type immediates: zero-latency combinational result
// plus a one-cycle registered copy with a valid flag.
module s_z_extend #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  s_z_extend_if.slave  bus
);

  generate
    if (OUT_W < IN_W) begin : g_width_check
      $error("s_z_extend: OUT_W must be >= IN_W");
    end
  endgenerate

  logic [OUT_W-1:0] ext_comb;
  logic [OUT_W-1:0] ext_data_q, ext_data_d;
  logic             ext_valid_q, ext_valid_d;

  assign ext_comb[IN_W-1:0] = bus.immediate;

  // One fill bit per upper position; the loop is empty when OUT_W == IN_W.
  genvar gi;
  generate
    for (gi = IN_W; gi < OUT_W; gi++) begin : g_fill
      assign ext_comb[gi] = bus.sext & bus.immediate[IN_W-1];
    end
  endgenerate

  always_comb begin
    ext_data_d  = ext_data_q;
    ext_valid_d = bus.in_valid;
    if (bus.in_valid) begin
      ext_data_d = ext_comb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_data_q  <= '0;
      ext_valid_q <= 1'b0;
    end else begin
      ext_data_q  <= ext_data_d;
      ext_valid_q <= ext_valid_d;
    end
  end

  assign bus.extendImmediate = ext_comb;
  assign bus.ext_q           = ext_data_q;
  assign bus.ext_valid       = ext_valid_q;

endmodule

// File: tb/tb_s_z_extend.sv
// Self-checking bench for s_z_extend: directed corner cases, then random
// imm/sext/in_valid/rst against an arithmetic reference model.
module tb_s_z_extend;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  logic [31:0] model_q;
  logic        model_v;

  s_z_extend_if #(.IN_W(16), .OUT_W(32)) bus ();

  s_z_extend #(.IN_W(16), .OUT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // Reference: value of the immediate read as signed or unsigned, mod 2^32.
  function automatic logic [31:0] ref_ext(input logic s, input logic [15:0] imm);
    int unsigned v;
    v = imm;
    if (s && imm >= 16'h8000) v = v + 32'hFFFF0000;
    return v;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic check_comb(input string tag);
    #1;
    check_val(tag, bus.extendImmediate, ref_ext(bus.sext, bus.immediate));
    $display("comb %s sext=%0d imm=%h ext=%h", tag, bus.sext, bus.immediate, bus.extendImmediate);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (rst) begin
      model_q = 32'h0;
      model_v = 1'b0;
    end else if (bus.in_valid) begin
      model_q = ref_ext(bus.sext, bus.immediate);
      model_v = 1'b1;
    end else begin
      model_v = 1'b0;
    end
    #1;
    check_val({tag, ".ext_q"}, bus.ext_q, model_q);
    check_val({tag, ".ext_valid"}, {31'b0, bus.ext_valid}, {31'b0, model_v});
    $display("reg %s rst=%0d ext_q=%h ext_valid=%0d", tag, rst, bus.ext_q, bus.ext_valid);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    model_q  = 32'h0;
    model_v  = 1'b0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.sext      = 1'b0;
    bus.immediate = 16'h0000;

    check_comb("zero");
    check_val("zero_const", bus.extendImmediate, 32'h00000000);

    bus.immediate = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      bus.sext = ~bus.sext;
      #20;
      check_val("ffff_toggle", bus.extendImmediate, bus.sext ? 32'hFFFFFFFF : 32'h0000FFFF);
    end

    bus.immediate = 16'h0FFF;
    bus.sext = 1'b1;
    check_comb("0fff_s");
    check_val("0fff_s_const", bus.extendImmediate, 32'h00000FFF);
    bus.sext = 1'b0;
    check_comb("0fff_z");

    bus.immediate = 16'h8000;
    bus.sext = 1'b1;
    check_comb("8000_s");
    check_val("8000_s_const", bus.extendImmediate, 32'hFFFF8000);
    bus.sext = 1'b0;
    check_comb("8000_z");
    check_val("8000_z_const", bus.extendImmediate, 32'h00008000);

    step("reset0");
    step("reset1");
    check_val("reset_q_const", bus.ext_q, 32'h0);

    rst           = 1'b0;
    bus.in_valid  = 1'b1;
    bus.sext      = 1'b1;
    bus.immediate = 16'h8001;
    step("cap8001");
    check_val("cap8001_const", bus.ext_q, 32'hFFFF8001);

    bus.in_valid  = 1'b0;
    bus.immediate = 16'h1234;
    step("hold");
    check_val("hold_const", bus.ext_q, 32'hFFFF8001);

    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.immediate = 16'h7777;
    step("rst_with_valid");

    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      rst           = ($urandom_range(0, 15) == 0);
      bus.in_valid  = $urandom_range(0, 1);
      bus.sext      = $urandom_range(0, 1);
      bus.immediate = 16'($urandom);
      check_comb("rand");
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
